// File: rtl/simd_agg_ctrl.sv
// Control stage around the external 16-lane SIMD add/sub datapath: streams neighbour
// vectors through the adder into a lane-wise accumulator and emits one result per node.
module simd_agg_ctrl #(
  parameter int unsigned LANES = 16,
  parameter int unsigned LW    = 8,
  parameter int unsigned DW    = 128,
  parameter int unsigned CW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_sub,
  input  logic          in_last,
  output logic [DW-1:0] add_a,
  output logic [DW-1:0] add_b,
  output logic          add_sub,
  input  logic [DW-1:0] add_cout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] out_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [LANES-1:0][LW-1:0]  acc_q, acc_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      out_valid_q, out_valid_d;
  logic [LANES-1:0][LW-1:0]  out_data_q, out_data_d;
  logic [CW-1:0]             out_count_q, out_count_d;

  logic          fresh;
  logic          accept;
  logic [CW-1:0] next_cnt;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;

    // A beat starts a new node whenever no partial sum is held (IDLE or HOLD).
    fresh    = (state_q != ACC);
    in_ready = (state_q != HOLD) | out_ready;
    accept   = in_valid & in_ready;
    next_cnt = fresh ? CW'(1) : sat_inc(cnt_q);

    add_a   = fresh ? '0 : acc_q;
    add_b   = in_data;
    add_sub = in_sub;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      state_d     = IDLE;
    end

    if (accept) begin
      if (in_last) begin
        out_data_d  = add_cout;
        out_count_d = next_cnt;
        out_valid_d = 1'b1;
        state_d     = HOLD;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d   = add_cout;
        cnt_d   = next_cnt;
        state_d = ACC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

endmodule
